mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req_valid0/1, input, 1 each, MEM-stage access request from core 0/1; held high until acknowledged.
REQ-006 SHALL have ports req_write0/1, req_half0/1, req_byte0/1, input, 1 each, store select and halfword/byte size selects.
REQ-007 SHALL have ports req_addr0/1 (input, ADDR_W) and req_wdata0/1 (input, DATA_W), access address and store data.
REQ-008 SHALL have ports stall0/1, output, 1 each, freeze the requesting core's pipeline.
REQ-009 SHALL have ports resp_valid0/1 (output, 1) and resp_rdata0/1 (output, DATA_W), access-complete strobe and load data.
REQ-010 SHALL have ports mem_en, mem_we, mem_half, mem_byte (output, 1 each), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W), the shared data-memory port.
REQ-011 SHALL have port mem_rdata, input, DATA_W, synchronous-read data, valid the cycle after mem_en.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS and RESP, plus a 1-bit owner register and a 1-bit priority pointer prio.
REQ-013 IDLE: if exactly one req_valid is high, that core SHALL be granted; if both are high, core prio SHALL be granted; if none, stay in IDLE.
REQ-014 On grant SHALL register the granted core's addr, wdata, write, half and byte onto the mem_* outputs, set owner, set prio to ~granted, and enter ACCESS.
REQ-015 ACCESS SHALL last exactly one cycle: mem_en=1 and mem_we=latched write; next state SHALL be RESP.
REQ-016 RESP: mem_en SHALL be 0, resp_valid[owner]=1 for exactly one cycle, and resp_rdata[owner]=mem_rdata (combinational pass-through); stores SHALL also pulse resp_valid.
REQ-017 stall_i SHALL equal req_valid_i AND NOT (state==RESP AND owner==i); the core advances at the end of its RESP cycle.
REQ-018 RESP arbitration SHALL consider only the non-owner core's req_valid: if high, grant it directly into ACCESS (same rules as REQ-014); otherwise go to IDLE.
REQ-019 Latency: request first sampled in IDLE at cycle T SHALL see mem_en at T+1 and resp_valid at T+2; two contending cores SHALL sustain one access per 2 cycles, strictly alternating.
REQ-020 Request inputs SHALL be sampled only at grant; changes during ACCESS/RESP SHALL NOT alter the in-flight access, and a request dropped mid-access SHALL still complete and pulse resp_valid.
REQ-021 resp_rdata of the non-owner, and of both cores outside RESP, SHALL be 0.
REQ-022 mem_half and mem_byte SHALL be forwarded unmodified; the arbiter SHALL NOT perform alignment or sign extension.

Reset
REQ-023 Rst_n low SHALL asynchronously force state=IDLE, owner=0, prio=0, and mem_* outputs to 0, at any point including mid-access; no resp_valid SHALL be issued for an aborted access.
REQ-024 While Rst_n is low, stall0/1 SHALL follow req_valid0/1 and resp_valid0/1 SHALL be 0.

Verification
REQ-025 Core 0 load alone, addr 0x10, mem_rdata 0xDEADBEEF at T+2 -> mem_en at T+1 with mem_addr 0x10, resp_valid0=1 and resp_rdata0=0xDEADBEEF at T+2, stall0 low from T+2.
REQ-026 Both cores request at T after reset (prio=0) -> core 0 ACCESS at T+1 and RESP at T+2, core 1 ACCESS at T+3 and RESP at T+4; stall1 stays high through T+3.
REQ-027 Both cores continuously requesting for 8 cycles -> grants strictly alternate 0,1,0,1 with mem_en on every other cycle.
REQ-028 Core 1 store addr 0x24, wdata 0x000000AB, byte=1 -> mem_we=1, mem_byte=1, mem_wdata=0xAB at T+1, resp_valid1 at T+2.
REQ-029 Rst_n pulsed low during ACCESS -> mem_en drops immediately, no resp_valid, FSM in IDLE and prio=0 after release; a held request is regranted.
REQ-030 Core 0 drops req_valid0 during ACCESS -> resp_valid0 still pulses at RESP, then IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-core arbiter for a single synchronous-read data-memory port.
// Each access takes one address cycle and one response cycle; contending cores alternate.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,

    input  logic              req_valid0,
    input  logic              req_write0,
    input  logic              req_half0,
    input  logic              req_byte0,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [DATA_W-1:0] req_wdata0,

    input  logic              req_valid1,
    input  logic              req_write1,
    input  logic              req_half1,
    input  logic              req_byte1,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata1,

    output logic              stall0,
    output logic              stall1,
    output logic              resp_valid0,
    output logic              resp_valid1,
    output logic [DATA_W-1:0] resp_rdata0,
    output logic [DATA_W-1:0] resp_rdata1,

    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_half,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic              grant;
    logic              grant_core;

    logic              we_q;
    logic              half_q;
    logic              byte_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              in_resp;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        grant      = 1'b0;
        grant_core = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid0 || req_valid1) begin
                    grant      = 1'b1;
                    grant_core = (req_valid0 && req_valid1) ? prio_q : req_valid1;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                // The owner is being released this cycle, so only the other core may win.
                if (owner_q ? req_valid0 : req_valid1) begin
                    grant      = 1'b1;
                    grant_core = ~owner_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (grant) begin
            state_d = ACCESS;
            owner_d = grant_core;
            prio_d  = ~grant_core;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            we_q    <= 1'b0;
            half_q  <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            if (grant) begin
                we_q    <= grant_core ? req_write1 : req_write0;
                half_q  <= grant_core ? req_half1  : req_half0;
                byte_q  <= grant_core ? req_byte1  : req_byte0;
                addr_q  <= grant_core ? req_addr1  : req_addr0;
                wdata_q <= grant_core ? req_wdata1 : req_wdata0;
            end
        end
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_half  = half_q;
    assign mem_byte  = byte_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign in_resp     = (state_q == RESP);
    assign resp_valid0 = in_resp & ~owner_q;
    assign resp_valid1 = in_resp &  owner_q;
    assign resp_rdata0 = resp_valid0 ? mem_rdata : '0;
    assign resp_rdata1 = resp_valid1 ? mem_rdata : '0;

    assign stall0 = req_valid0 & ~resp_valid0;
    assign stall1 = req_valid1 & ~resp_valid1;

endmodule
